division_seq: RTL and testbench
===============================

Name: division_seq

Overview:
- Sequential radix-4 restoring divider: in_a / in_b -> quotient and remainder. It is the inverse-direction companion to the team's combinational radix-4 multiplication block.
- Retires 2 quotient bits per clock. Bit-exact against in_a / in_b and in_a % in_b.
- Start/busy/done handshake. Placed next to the multiplier in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be even and >= 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled on the rising edge of clk
- in_a  in  WIDTH  dividend, captured on an accepted start
- in_b  in  WIDTH  divisor, captured on an accepted start
- busy  out  1  high while state CALC
- done  out  1  one-cycle pulse; quot/rem/div_by_zero valid from this cycle
- quot  out  WIDTH  quotient
- rem  out  WIDTH  remainder
- div_by_zero  out  1  last accepted operation had in_b == 0

Behaviour:
- Single clock domain. Synchronous, active-high reset. All state changes on the rising edge of clk.
- Reset: state IDLE; busy=0, done=0, quot=0, rem=0, div_by_zero=0. rst has priority over start.
- Reset mid-operation aborts the division. No done pulse is produced and outputs return to 0.
- States: IDLE, CALC, DONE.
  - IDLE: start=1 -> capture in_a, in_b; clear the partial remainder and iteration counter.
    - in_b != 0 -> CALC.
    - in_b == 0 -> DONE.
  - CALC: one radix-4 step per edge. N = WIDTH/2 steps total.
    - Shift the top 2 dividend bits into the partial remainder P.
    - Compare P against 3D, 2D, D (D = divisor); all comparisons are WIDTH+2 bits wide, no truncation.
    - Pick the largest multiple q in {0,1,2,3} with q*D <= P. Subtract it and append q to the quotient.
    - After step N -> DONE.
  - DONE: done=1 for exactly this cycle; quot, rem, div_by_zero updated in this cycle.
    - start=1 -> accepted exactly as in IDLE (back-to-back operation).
    - Otherwise -> IDLE.
- start while in CALC is ignored: no capture, no effect on the operation in flight.
- Latency: start accepted at edge E0.
  - Normal: done high in the cycle after edge E(N), i.e. N clocks after E0. WIDTH=16 -> 8 clocks.
  - busy high for exactly N cycles.
- Divide by zero: done high in the cycle after E0 (1 clock); busy stays 0.
  - quot = all ones, rem = in_a, div_by_zero = 1.
- Held results: quot, rem and div_by_zero hold their values until the next DONE or reset.
  - They do not change during CALC.
  - div_by_zero is cleared on the next non-zero-divisor completion.
- Unsigned (default): quot = floor(in_a / in_b), rem = in_a - quot*in_b, so 0 <= rem < in_b.
- Boundaries:
  - in_a < in_b -> quot=0, rem=in_a.
  - in_b=1 -> quot=in_a, rem=0.
  - Max operands (all ones / all ones) -> quot=1, rem=0.

Optional Feature:
- Macro DIVISION_SIGNED_EN.
- Defined: operands are two's complement.
  - Take the magnitudes at capture, run the same unsigned core, and apply signs at DONE. Latency is unchanged.
  - Quotient truncates toward zero; rem takes the sign of the dividend.
  - Overflow case (-2^(WIDTH-1)) / (-1) -> quot = -2^(WIDTH-1), rem=0, div_by_zero=0.
  - Divide by zero -> quot = all ones, rem = in_a, div_by_zero=1.
- Undefined: pure unsigned behaviour as specified above; no sign logic is synthesized.

Test Plan:
- WIDTH=16: in_a=1000, in_b=7, start 1 cycle -> done exactly 8 clocks later, quot=142, rem=6, busy high for 8 cycles, div_by_zero=0.
- in_a=65535, in_b=1 -> quot=65535, rem=0. Then in_a=3, in_b=65535 -> quot=0, rem=3. Then in_a=65535, in_b=65535 -> quot=1, rem=0.
- in_a=5, in_b=0 -> done 1 clock after start, quot=0xFFFF, rem=5, div_by_zero=1, busy never high. A following 9/3 -> quot=3, rem=0, div_by_zero=0.
- start 200/9, then pulse start with 1/1 at clock 3 of CALC -> ignored, result quot=22, rem=2. Start 50/5 in the DONE cycle -> accepted, second done 8 clocks later, quot=10, rem=0.
- start 1000/7, assert rst at clock 4 of CALC -> no done pulse, all outputs 0 next cycle, state IDLE. A new start works normally afterwards.
- DIVISION_SIGNED_EN defined:
  - -7/2 -> quot=0xFFFD, rem=0xFFFF.
  - 7/-2 -> quot=0xFFFD, rem=1.
  - 0x8000/0xFFFF -> quot=0x8000, rem=0.
  - Random signed sweep vs reference model; all pass.

Source files
------------

// File: rtl/division_seq.sv
// Sequential radix-4 restoring divider: retires two quotient bits per clock with a start/busy/done handshake.
// Optional two's-complement operation is enabled by defining DIVISION_SIGNED_EN.
module division_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int STEPS = WIDTH / 2;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int PW    = WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  // dvd_r shifts dividend bits out of the top while quotient digits shift in at the bottom
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] prem_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [PW-1:0]    p_shift_s;
  logic [PW-1:0]    d1_s;
  logic [PW-1:0]    d2_s;
  logic [PW-1:0]    d3_s;
  logic [1:0]       qd_s;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] q_final_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

`ifdef DIVISION_SIGNED_EN
  logic             neg_q_r;
  logic             neg_r_r;
`endif

  // Operand conditioning at capture: magnitudes in signed mode, pass-through otherwise.
  always_comb begin
    a_mag_s = in_a;
    b_mag_s = in_b;
`ifdef DIVISION_SIGNED_EN
    if (in_a[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - in_a;
    end else begin
      a_mag_s = in_a;
    end
    if (in_b[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - in_b;
    end else begin
      b_mag_s = in_b;
    end
`endif
  end

  // One radix-4 step: choose the largest q in 0..3 with q*D <= P, all at full WIDTH+2 precision.
  always_comb begin
    p_shift_s = {prem_r, dvd_r[WIDTH-1 -: 2]};
    d1_s      = {2'b00, dvs_r};
    d2_s      = {1'b0, dvs_r, 1'b0};
    d3_s      = d1_s + d2_s;
    qd_s      = 2'd0;
    p_next_s  = WIDTH'(p_shift_s);
    if (p_shift_s >= d3_s) begin
      qd_s     = 2'd3;
      p_next_s = WIDTH'(p_shift_s - d3_s);
    end else if (p_shift_s >= d2_s) begin
      qd_s     = 2'd2;
      p_next_s = WIDTH'(p_shift_s - d2_s);
    end else if (p_shift_s >= d1_s) begin
      qd_s     = 2'd1;
      p_next_s = WIDTH'(p_shift_s - d1_s);
    end else begin
      qd_s     = 2'd0;
      p_next_s = WIDTH'(p_shift_s);
    end
    q_final_s = {dvd_r[WIDTH-3:0], qd_s};
  end

  // Result sign correction applied on the final step.
  always_comb begin
    quot_fix_s = q_final_s;
    rem_fix_s  = p_next_s;
`ifdef DIVISION_SIGNED_EN
    if (neg_q_r) begin
      quot_fix_s = {WIDTH{1'b0}} - q_final_s;
    end else begin
      quot_fix_s = q_final_s;
    end
    if (neg_r_r) begin
      rem_fix_s = {WIDTH{1'b0}} - p_next_s;
    end else begin
      rem_fix_s = p_next_s;
    end
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dvd_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      prem_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= {WIDTH{1'b0}};
      rem         <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
`ifdef DIVISION_SIGNED_EN
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        // DONE accepts a new start exactly like IDLE, giving back-to-back operation
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dvd_r  <= a_mag_s;
            dvs_r  <= b_mag_s;
            prem_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
`ifdef DIVISION_SIGNED_EN
            neg_q_r <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            neg_r_r <= in_a[WIDTH-1];
`endif
            if (in_b == {WIDTH{1'b0}}) begin
              state_r     <= DONE;
              done        <= 1'b1;
              quot        <= {WIDTH{1'b1}};
              rem         <= in_a;
              div_by_zero <= 1'b1;
            end else begin
              state_r <= CALC;
              busy    <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          dvd_r  <= {dvd_r[WIDTH-3:0], qd_s};
          prem_r <= p_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_STEP) begin
            state_r     <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quot        <= quot_fix_s;
            rem         <= rem_fix_s;
            div_by_zero <= 1'b0;
          end else begin
            state_r <= CALC;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division_seq.sv
// Self-checking bench for division_seq (WIDTH=16): directed handshake cases plus a random sweep
// against an arithmetic reference model; honours DIVISION_SIGNED_EN when defined.
module tb_division_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;
  logic         last_z;

  division_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain language-level division with the divide-by-zero convention.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
`ifdef DIVISION_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIVISION_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after acceptance until done, bounded; also counts busy cycles seen.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int lat;
    int bc;
    model(a, b, eq, er, ez);
    launch(a, b);
    wait_done(lat, bc);
    chk("latency", lat, ez ? 0 : 8);
    chk("busy_cycles", bc, ez ? 0 : 8);
    chk("busy_at_done", busy, 1'b0);
    chk("quot", quot, eq);
    chk("rem", rem, er);
    chk("div_by_zero", div_by_zero, ez);
    last_q = eq;
    last_r = er;
    last_z = ez;
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;

    rst   = 1'b1;
    start = 1'b0;
    in_a  = 16'd0;
    in_b  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quot", quot, 16'd0);
    chk("rst_rem", rem, 16'd0);
    chk("rst_dbz", div_by_zero, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic operation and single-cycle done pulse
    do_op(16'd1000, 16'd7);
    chk("q_1000_7", quot, 16'd142);
    chk("r_1000_7", rem, 16'd6);
    @(posedge clk);
    #1;
    chk("done_pulse", done, 1'b0);
    chk("quot_held", quot, 16'd142);

    // Boundaries
    do_op(16'hFFFF, 16'd1);
    do_op(16'd3, 16'hFFFF);
    do_op(16'hFFFF, 16'hFFFF);
    @(posedge clk);
    #1;

    // Divide by zero then normal clears the flag
    do_op(16'd5, 16'd0);
    chk("dz_quot", quot, 16'hFFFF);
    chk("dz_rem", rem, 16'd5);
    @(posedge clk);
    #1;
    do_op(16'd9, 16'd3);
    @(posedge clk);
    #1;

    // start during CALC is ignored; results held during CALC
    model(16'd200, 16'd9, eq, er, ez);
    launch(16'd200, 16'd9);
    chk("busy_calc", busy, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("hold_quot_calc", quot, last_q);
    chk("hold_rem_calc", rem, last_r);
    launch(16'd1, 16'd1);
    wait_done(lat, bc);
    chk("ign_latency", lat, 5);
    chk("ign_quot", quot, eq);
    chk("ign_rem", rem, er);
    chk("ign_q22", quot, 16'd22);

    // Back-to-back start in the DONE cycle
    do_op(16'd50, 16'd5);
    chk("b2b_q10", quot, 16'd10);
    @(posedge clk);
    #1;

    // Reset mid-operation aborts
    launch(16'd1000, 16'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_quot", quot, 16'd0);
    chk("abort_rem", rem, 16'd0);
    chk("abort_dbz", div_by_zero, 1'b0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("abort_no_activity", seen, 0);
    do_op(16'd1000, 16'd7);
    @(posedge clk);
    #1;

`ifdef DIVISION_SIGNED_EN
    do_op(16'hFFF9, 16'd2);
    chk("s_q_m7_2", quot, 16'hFFFD);
    chk("s_r_m7_2", rem, 16'hFFFF);
    do_op(16'd7, 16'hFFFE);
    chk("s_q_7_m2", quot, 16'hFFFD);
    chk("s_r_7_m2", rem, 16'd1);
    do_op(16'h8000, 16'hFFFF);
    chk("s_q_ovf", quot, 16'h8000);
    chk("s_r_ovf", rem, 16'd0);
    chk("s_z_ovf", div_by_zero, 1'b0);
    @(posedge clk);
    #1;
`endif

    // Random sweep, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1, 2:    rb = 16'($urandom_range(1, 15));
        3:       rb = 16'hFFFF - 16'($urandom_range(0, 3));
        default: rb = 16'($urandom);
      endcase
      do_op(ra, rb);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
        chk("rnd_pulse", done, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
